accel_ctrl_regs: RTL and testbench
==================================

Name: accel_ctrl_regs

Overview:
Parametrised control/status register block for the lane-detection accelerator's AXI-lite window. It replaces the fixed OVALID/BUSY/RESET decode with a configurable register file. New functions: programmable soft-reset pulse, frame/latency counters, watchdog timeout, overrun detection, and a maskable interrupt with write-1-to-clear status. It sits beside the data path and drives the soft reset consumed by the input FIFO, model and post-process.

Parameters:
AXI_ADDR_WIDTH, 20, width of axi_wr_addr/axi_rd_addr.
BASE_ADDR, 395264, byte address of register 0; must be 4-byte aligned.
SOFT_RESET_CYCLES, 15, soft_rst pulse length in cycles (1..255).
CNT_WIDTH, 32, width of the latency counter and timeout limit (8..32).
FRAME_CNT_WIDTH, 16, width of the frame counter (1..32).

Ports:
clk  in  1  single clock for all logic.
rst  in  1  asynchronous, active-high reset.
axi_wr_data  in  32  write data.
axi_wr_addr  in  AXI_ADDR_WIDTH  byte write address.
axi_wr_strobe  in  4  byte enables.
axi_wr_en  in  1  write strobe, one write per cycle.
axi_rd_addr  in  AXI_ADDR_WIDTH  byte read address.
axi_rd_en  in  1  read request.
axi_rd_data  out  32  registered read data.
axi_rd_hit  out  1  registered; 1 when the previous cycle's read hit this window.
frame_start  in  1  one-cycle pulse on the first pixel of a frame.
frame_done  in  1  level; post-process output-valid.
soft_rst  out  1  active-high reset to the data path; equals rst OR pulse active.
busy  out  1  frame in flight.
irq  out  1  level interrupt.

Behaviour:
Register map (offset from BASE_ADDR, word-aligned; other bits read 0):
- +0x00 VALID (RO): bit0 = frame_done.
- +0x04 BUSY (RO): bit0 = busy.
- +0x08 RESET (WO): writing bit0=1 with strobe[0] starts soft reset. Reads 0.
- +0x0C CTRL (RW, byte strobes): bit0 irq_en, bit1 timeout_en. Reset value 0.
- +0x10 STATUS (W1C, strobe[0]): bit0 done, bit1 timeout, bit2 overrun.
- +0x14 FRAME_COUNT (RO): completed frames, wraps to 0.
- +0x18 LAST_LATENCY (RO): cycles from frame_start to done/timeout of the last frame.
- +0x1C TIMEOUT_LIMIT (RW, byte strobes): reset value all ones, truncated to CNT_WIDTH.

Register access:
- Unaligned or out-of-map addresses are ignored on write and read as 0.
- A hit means BASE_ADDR <= addr < BASE_ADDR+0x20.

Reset (rst=1):
- All registers take their reset values.
- Counters are 0, soft_rst=1, busy=0, irq=0, axi_rd_data=0, axi_rd_hit=0.

Soft reset:
- The RESET write loads an 8-bit down-counter with SOFT_RESET_CYCLES.
- soft_rst is high from the cycle after the write for exactly SOFT_RESET_CYCLES cycles.
- RESET writes while the counter is nonzero are ignored; the pulse is not extended.
- While soft_rst is high: busy, the cycle counter, STATUS, FRAME_COUNT and LAST_LATENCY clear and hold at 0, and frame_start is ignored.
- CTRL and TIMEOUT_LIMIT are retained.

Frame FSM, states IDLE and RUN:
- IDLE -> RUN on frame_start; the cycle counter is loaded with 1.
- In RUN the counter increments each cycle and saturates at all ones.
- RUN -> IDLE on the rising edge of frame_done (frame_done=1 while the previous sample was 0). On that edge:
  - LAST_LATENCY <= counter.
  - FRAME_COUNT += 1.
  - STATUS.done <= 1.
- RUN -> IDLE on timeout when timeout_en=1 and counter >= TIMEOUT_LIMIT. On timeout:
  - LAST_LATENCY <= counter.
  - STATUS.timeout <= 1.
  - FRAME_COUNT is unchanged.
- If done and timeout occur in the same cycle, done wins.
- frame_start in RUN: STATUS.overrun <= 1 and the FSM state is unchanged.
- frame_start in the same cycle as the done edge: the FSM returns to IDLE. It does not restart and overrun is not set.
- busy = (state==RUN) AND NOT frame_done.

STATUS rules:
- Bits are sticky; writing 1 clears a bit.
- A set event in the same cycle as its clear leaves the bit at 1.

irq = irq_en AND (done OR timeout OR overrun), registered (1-cycle latency after the status bit sets).

Reads:
- axi_rd_data and axi_rd_hit update on the cycle after axi_rd_en=1.
- If axi_rd_en=0 both hold their values.
- Read data reflects register contents at the request cycle.
- A write and a read to the same register in the same cycle return the old value.

Test Plan:
- rst pulse, then RESET write data=1, strobe=0x1 -> soft_rst high for exactly 15 cycles starting the next cycle. A second RESET write at pulse cycle 5 -> still 15 cycles. CTRL value retained.
- frame_start, then frame_done rises 1000 cycles later -> busy=1 for cycles 1..999, then 0. LAST_LATENCY=1000, FRAME_COUNT=1, STATUS=0x1. With irq_en=1, irq=1 one cycle after done.
- timeout_en=1, TIMEOUT_LIMIT=50, frame_start, no done -> RUN exits when counter reaches 50. STATUS.timeout=1, LAST_LATENCY=50, FRAME_COUNT unchanged.
- frame_start twice within one frame -> STATUS=0x4 after the second pulse, busy unchanged. W1C write of 0x4 clears it. A W1C in the same cycle as a new overrun leaves the bit at 1.
- Read every offset, BASE_ADDR+0x20, and an address below BASE_ADDR -> mapped values one cycle later with axi_rd_hit=1. Out-of-window reads give axi_rd_data=0, axi_rd_hit=0.
- Write TIMEOUT_LIMIT with strobe=0x2, data=0xAABBCCDD -> register = 0xFFFFCCFF.

Source files
------------

// File: rtl/accel_ctrl_regs_if.sv
// ---------------------------------------------------------------------------
// accel_ctrl_regs_if
// Register-window bus of the lane-detection accelerator control block.
// One write and one read channel, both single-cycle; read data returns on
// the cycle after the request.
//   axi_wr_data   [31:0]      write data
//   axi_wr_addr   [ADDR_W-1:0] byte write address
//   axi_wr_strobe [3:0]       byte enables
//   axi_wr_en                 write strobe, one write per cycle
//   axi_rd_addr   [ADDR_W-1:0] byte read address
//   axi_rd_en                 read request
//   axi_rd_data   [31:0]      registered read data (slave output)
//   axi_rd_hit                registered window-hit flag (slave output)
// ---------------------------------------------------------------------------
interface accel_ctrl_regs_if #(
    parameter int ADDR_W = 20
);
    logic [31:0]       axi_wr_data;
    logic [ADDR_W-1:0] axi_wr_addr;
    logic [3:0]        axi_wr_strobe;
    logic              axi_wr_en;
    logic [ADDR_W-1:0] axi_rd_addr;
    logic              axi_rd_en;
    logic [31:0]       axi_rd_data;
    logic              axi_rd_hit;

    modport slave (
        input  axi_wr_data, axi_wr_addr, axi_wr_strobe, axi_wr_en,
        input  axi_rd_addr, axi_rd_en,
        output axi_rd_data, axi_rd_hit
    );

    modport master (
        output axi_wr_data, axi_wr_addr, axi_wr_strobe, axi_wr_en,
        output axi_rd_addr, axi_rd_en,
        input  axi_rd_data, axi_rd_hit
    );
endinterface

// File: rtl/accel_ctrl_regs.sv
// ---------------------------------------------------------------------------
// accel_ctrl_regs
// Control/status register window for the lane-detection accelerator:
// soft-reset pulse generator, frame FSM with latency counter, frame counter,
// watchdog timeout, overrun detection and a maskable, write-1-to-clear
// interrupt.
//   clk, rst      single clock, asynchronous active-high reset
//   bus           register-window bus (slave side)
//   frame_start   one-cycle pulse on the first pixel of a frame
//   frame_done    level, post-process output-valid
//   soft_rst      reset to the data path: rst OR soft-reset pulse
//   busy          frame in flight
//   irq           level interrupt
// Map (offset from BASE_ADDR): 00 VALID, 04 BUSY, 08 RESET, 0C CTRL,
// 10 STATUS, 14 FRAME_COUNT, 18 LAST_LATENCY, 1C TIMEOUT_LIMIT.
// ---------------------------------------------------------------------------
module accel_ctrl_regs #(
    parameter int AXI_ADDR_WIDTH    = 20,
    parameter int BASE_ADDR         = 395264,
    parameter int SOFT_RESET_CYCLES = 15,
    parameter int CNT_WIDTH         = 32,
    parameter int FRAME_CNT_WIDTH   = 16
) (
    input  logic              clk,
    input  logic              rst,
    accel_ctrl_regs_if.slave  bus,
    input  logic              frame_start,
    input  logic              frame_done,
    output logic              soft_rst,
    output logic              busy,
    output logic              irq
);

    localparam logic [AXI_ADDR_WIDTH-1:0] LP_BASE  = AXI_ADDR_WIDTH'(BASE_ADDR);
    localparam logic [AXI_ADDR_WIDTH-1:0] LP_SPAN  = AXI_ADDR_WIDTH'(32);
    localparam logic [7:0]                LP_SRST  = 8'(SOFT_RESET_CYCLES);

    localparam logic [2:0] IDX_VALID  = 3'd0;
    localparam logic [2:0] IDX_BUSY   = 3'd1;
    localparam logic [2:0] IDX_RESET  = 3'd2;
    localparam logic [2:0] IDX_CTRL   = 3'd3;
    localparam logic [2:0] IDX_STATUS = 3'd4;
    localparam logic [2:0] IDX_FCNT   = 3'd5;
    localparam logic [2:0] IDX_LAT    = 3'd6;
    localparam logic [2:0] IDX_TLIM   = 3'd7;

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t                       r_state, w_state_nxt;
    logic [7:0]                   r_srst_cnt;
    logic [1:0]                   r_ctrl;      // [0] irq_en, [1] timeout_en
    logic [2:0]                   r_status;    // [0] done, [1] timeout, [2] overrun
    logic [FRAME_CNT_WIDTH-1:0]   r_fcnt;
    logic [CNT_WIDTH-1:0]         r_cnt;
    logic [CNT_WIDTH-1:0]         r_lat;
    logic [CNT_WIDTH-1:0]         r_tlimit;
    logic                         r_fd_prev;
    logic                         r_irq;
    logic [31:0]                  r_rd_data;
    logic                         r_rd_hit;

    // ---------------------------------------------------------------- decode
    logic [AXI_ADDR_WIDTH-1:0] w_wr_rel, w_rd_rel;
    logic                      w_wr_hit, w_rd_hit, w_wr_sel;
    logic [2:0]                w_wr_idx;

    // Base is word aligned, so the relative address carries the alignment.
    assign w_wr_rel = bus.axi_wr_addr - LP_BASE;
    assign w_rd_rel = bus.axi_rd_addr - LP_BASE;
    assign w_wr_hit = (bus.axi_wr_addr >= LP_BASE) && (w_wr_rel < LP_SPAN);
    assign w_rd_hit = (bus.axi_rd_addr >= LP_BASE) && (w_rd_rel < LP_SPAN);
    assign w_wr_sel = bus.axi_wr_en && w_wr_hit && (w_wr_rel[1:0] == 2'b00);
    assign w_wr_idx = w_wr_rel[4:2];

    logic w_srst_act, w_srst_start, w_sclr;
    logic w_ctrl_wr, w_stat_wr, w_tlim_wr;

    assign w_srst_act   = (r_srst_cnt != 8'd0);
    // A RESET write during an active pulse is dropped, so it never stretches.
    assign w_srst_start = w_wr_sel && (w_wr_idx == IDX_RESET) && bus.axi_wr_strobe[0]
                          && bus.axi_wr_data[0] && !w_srst_act;
    // Clear also on the write cycle so the datapath state is already zero on
    // the first cycle soft_rst is visible.
    assign w_sclr       = w_srst_act || w_srst_start;
    assign w_ctrl_wr    = w_wr_sel && (w_wr_idx == IDX_CTRL) && bus.axi_wr_strobe[0];
    assign w_stat_wr    = w_wr_sel && (w_wr_idx == IDX_STATUS) && bus.axi_wr_strobe[0];
    assign w_tlim_wr    = w_wr_sel && (w_wr_idx == IDX_TLIM);

    // ------------------------------------------------------------ soft reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_srst_cnt <= 8'd0;
        end else if (w_srst_start) begin
            r_srst_cnt <= LP_SRST;
        end else if (w_srst_act) begin
            r_srst_cnt <= r_srst_cnt - 8'd1;
        end
    end

    assign soft_rst = rst || w_srst_act;

    // -------------------------------------------------------------- frame FSM
    logic w_done_edge, w_to_hit;
    logic w_done_ev, w_to_ev, w_ovr_ev, w_start_ev;

    assign w_done_edge = frame_done && !r_fd_prev;
    assign w_to_hit    = r_ctrl[1] && (r_cnt >= r_tlimit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_ev   = 1'b0;
        w_to_ev     = 1'b0;
        w_ovr_ev    = 1'b0;
        w_start_ev  = 1'b0;
        if (w_sclr) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (frame_start) begin
                        w_state_nxt = S_RUN;
                        w_start_ev  = 1'b1;
                    end
                end
                S_RUN: begin
                    // Done edge wins over timeout and swallows a coincident start.
                    if (w_done_edge) begin
                        w_state_nxt = S_IDLE;
                        w_done_ev   = 1'b1;
                    end else begin
                        if (w_to_hit) begin
                            w_state_nxt = S_IDLE;
                            w_to_ev     = 1'b1;
                        end
                        if (frame_start) begin
                            w_ovr_ev = 1'b1;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign busy = (r_state == S_RUN) && !frame_done;

    // ------------------------------------------------------ counters, status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fd_prev <= 1'b0;
            r_cnt     <= '0;
            r_lat     <= '0;
            r_fcnt    <= '0;
            r_status  <= 3'b000;
        end else begin
            r_fd_prev <= frame_done;
            if (w_sclr) begin
                r_cnt    <= '0;
                r_lat    <= '0;
                r_fcnt   <= '0;
                r_status <= 3'b000;
            end else begin
                if (w_start_ev) begin
                    r_cnt <= CNT_WIDTH'(1);
                end else if (r_state == S_RUN && r_cnt != '1) begin
                    r_cnt <= r_cnt + CNT_WIDTH'(1);
                end
                if (w_done_ev || w_to_ev) begin
                    r_lat <= r_cnt;
                end
                if (w_done_ev) begin
                    r_fcnt <= r_fcnt + FRAME_CNT_WIDTH'(1);
                end
                // Set dominates a same-cycle write-1-to-clear.
                r_status <= (r_status & ~(w_stat_wr ? bus.axi_wr_data[2:0] : 3'b000))
                          | {w_ovr_ev, w_to_ev, w_done_ev};
            end
        end
    end

    // ------------------------------------------------------- CTRL / TIMEOUT
    logic [31:0] w_tl_ext, w_tl_new;

    always_comb begin
        w_tl_ext = '0;
        w_tl_ext[CNT_WIDTH-1:0] = r_tlimit;
        w_tl_new = w_tl_ext;
        for (int b = 0; b < 4; b++) begin
            if (bus.axi_wr_strobe[b]) begin
                w_tl_new[8*b +: 8] = bus.axi_wr_data[8*b +: 8];
            end
        end
    end

    // Configuration survives the soft reset; only rst clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl   <= 2'b00;
            r_tlimit <= '1;
        end else begin
            if (w_ctrl_wr) begin
                r_ctrl <= bus.axi_wr_data[1:0];
            end
            if (w_tlim_wr) begin
                r_tlimit <= w_tl_new[CNT_WIDTH-1:0];
            end
        end
    end

    // --------------------------------------------------------------- irq
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_ctrl[0] && (r_status != 3'b000);
        end
    end

    assign irq = r_irq;

    // -------------------------------------------------------------- reads
    logic [31:0] w_rd_word;

    always_comb begin
        w_rd_word = '0;
        case (w_rd_rel[4:2])
            IDX_VALID:  w_rd_word[0] = frame_done;
            IDX_BUSY:   w_rd_word[0] = busy;
            IDX_RESET:  w_rd_word = '0;
            IDX_CTRL:   w_rd_word[1:0] = r_ctrl;
            IDX_STATUS: w_rd_word[2:0] = r_status;
            IDX_FCNT:   w_rd_word[FRAME_CNT_WIDTH-1:0] = r_fcnt;
            IDX_LAT:    w_rd_word[CNT_WIDTH-1:0] = r_lat;
            IDX_TLIM:   w_rd_word[CNT_WIDTH-1:0] = r_tlimit;
            default:    w_rd_word = '0;
        endcase
        if (!w_rd_hit || w_rd_rel[1:0] != 2'b00) begin
            w_rd_word = '0;
        end
    end

    // Sampled from pre-edge register contents, so a same-cycle write is not
    // visible to the read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
            r_rd_hit  <= 1'b0;
        end else if (bus.axi_rd_en) begin
            r_rd_data <= w_rd_word;
            r_rd_hit  <= w_rd_hit;
        end
    end

    assign bus.axi_rd_data = r_rd_data;
    assign bus.axi_rd_hit  = r_rd_hit;

endmodule

// File: tb/tb_accel_ctrl_regs.sv
// ---------------------------------------------------------------------------
// tb_accel_ctrl_regs
// Directed bench for accel_ctrl_regs: read-map table plus hand sequences for
// soft reset, frame latency, timeout, overrun and byte-strobe writes.
// ---------------------------------------------------------------------------
module tb_accel_ctrl_regs;

    localparam logic [19:0] BASE = 20'h60800;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frame_start = 1'b0;
    logic frame_done  = 1'b0;
    logic soft_rst, busy, irq;

    int n_chk = 0;
    int n_err = 0;

    accel_ctrl_regs_if #(.ADDR_W(20)) bus ();

    accel_ctrl_regs #(
        .AXI_ADDR_WIDTH(20), .BASE_ADDR(395264), .SOFT_RESET_CYCLES(15),
        .CNT_WIDTH(32), .FRAME_CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .frame_start(frame_start), .frame_done(frame_done),
        .soft_rst(soft_rst), .busy(busy), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    typedef struct {
        logic [19:0] addr;
        logic [31:0] exp_d;
        logic        exp_h;
    } rd_vec_t;

    rd_vec_t tbl [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [19:0] a, input logic [31:0] d, input logic [3:0] s);
        bus.axi_wr_addr   = a;
        bus.axi_wr_data   = d;
        bus.axi_wr_strobe = s;
        bus.axi_wr_en     = 1'b1;
        tick();
        bus.axi_wr_en     = 1'b0;
    endtask

    task automatic rd(input logic [19:0] a, output logic [31:0] d, output logic h);
        bus.axi_rd_addr = a;
        bus.axi_rd_en   = 1'b1;
        tick();
        bus.axi_rd_en   = 1'b0;
        d = bus.axi_rd_data;
        h = bus.axi_rd_hit;
    endtask

    task automatic rd_chk(input string nm, input logic [19:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic        h;
        rd(a, d, h);
        chk(nm, d, exp);
        chk({nm, "_hit"}, {31'd0, h}, 32'd1);
    endtask

    initial begin
        logic [31:0] d;
        logic        h;
        int          n;

        bus.axi_wr_data = '0; bus.axi_wr_addr = '0; bus.axi_wr_strobe = '0;
        bus.axi_wr_en = 1'b0; bus.axi_rd_addr = '0; bus.axi_rd_en = 1'b0;

        // ---- reset state
        repeat (3) tick();
        chk("rst_soft_rst", {31'd0, soft_rst}, 32'd1);
        chk("rst_busy",     {31'd0, busy},     32'd0);
        chk("rst_irq",      {31'd0, irq},      32'd0);
        chk("rst_rd_data",  bus.axi_rd_data,   32'd0);
        chk("rst_rd_hit",   {31'd0, bus.axi_rd_hit}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_soft_rst", {31'd0, soft_rst}, 32'd0);
        tick();

        // ---- soft reset pulse, retrigger ignored, CTRL retained
        wr(BASE + 20'h0C, 32'h3, 4'h1);
        wr(BASE + 20'h08, 32'h1, 4'h1);
        n = 0;
        for (int i = 0; i < 25; i++) begin
            if (soft_rst) n++;
            if (i == 0) chk("srst_first_cycle", {31'd0, soft_rst}, 32'd1);
            if (i == 4) begin
                bus.axi_wr_addr = BASE + 20'h08; bus.axi_wr_data = 32'h1;
                bus.axi_wr_strobe = 4'h1; bus.axi_wr_en = 1'b1;
            end
            tick();
            bus.axi_wr_en = 1'b0;
        end
        chk("srst_len", n, 32'd15);
        rd_chk("srst_ctrl_kept", BASE + 20'h0C, 32'h3);

        // ---- frame latency with irq
        wr(BASE + 20'h0C, 32'h1, 4'h1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        n = 0;
        for (int i = 1; i <= 999; i++) begin
            if (busy) n++;
            tick();
        end
        chk("lat_busy_cycles", n, 32'd999);
        frame_done = 1'b1;
        #1;
        chk("lat_busy_done", {31'd0, busy}, 32'd0);
        tick();
        chk("lat_irq_early", {31'd0, irq}, 32'd0);
        tick();
        chk("lat_irq", {31'd0, irq}, 32'd1);

        // ---- read map table (frame_done still high)
        tbl[0]  = '{BASE + 20'h00, 32'h1,        1'b1};
        tbl[1]  = '{BASE + 20'h04, 32'h0,        1'b1};
        tbl[2]  = '{BASE + 20'h08, 32'h0,        1'b1};
        tbl[3]  = '{BASE + 20'h0C, 32'h1,        1'b1};
        tbl[4]  = '{BASE + 20'h10, 32'h1,        1'b1};
        tbl[5]  = '{BASE + 20'h14, 32'd1,        1'b1};
        tbl[6]  = '{BASE + 20'h18, 32'd1000,     1'b1};
        tbl[7]  = '{BASE + 20'h1C, 32'hFFFFFFFF, 1'b1};
        tbl[8]  = '{BASE + 20'h20, 32'h0,        1'b0};
        tbl[9]  = '{BASE - 20'h04, 32'h0,        1'b0};
        tbl[10] = '{BASE + 20'h0D, 32'h0,        1'b1};
        for (int i = 0; i < 11; i++) begin
            rd(tbl[i].addr, d, h);
            chk($sformatf("map%0d_data", i), d, tbl[i].exp_d);
            chk($sformatf("map%0d_hit", i), {31'd0, h}, {31'd0, tbl[i].exp_h});
        end

        // ---- W1C clears done, irq drops
        wr(BASE + 20'h10, 32'h1, 4'h1);
        tick();
        chk("w1c_irq_low", {31'd0, irq}, 32'd0);
        rd_chk("w1c_status", BASE + 20'h10, 32'h0);

        // ---- timeout
        frame_done = 1'b0;
        wr(BASE + 20'h0C, 32'h2, 4'h1);
        wr(BASE + 20'h1C, 32'd50, 4'hF);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            n++;
            tick();
        end
        chk("to_run_cycles", n, 32'd50);
        rd_chk("to_status", BASE + 20'h10, 32'h2);
        rd_chk("to_latency", BASE + 20'h18, 32'd50);
        rd_chk("to_fcnt", BASE + 20'h14, 32'd1);

        // ---- write and read same register in one cycle returns old value
        bus.axi_wr_addr = BASE + 20'h0C; bus.axi_wr_data = 32'h1;
        bus.axi_wr_strobe = 4'h1; bus.axi_wr_en = 1'b1;
        rd(BASE + 20'h0C, d, h);
        bus.axi_wr_en = 1'b0;
        chk("rw_same_old", d, 32'h2);
        rd_chk("rw_same_new", BASE + 20'h0C, 32'h1);

        // ---- overrun
        wr(BASE + 20'h0C, 32'h0, 4'h1);
        wr(BASE + 20'h10, 32'h7, 4'h1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (3) tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("ovr_busy", {31'd0, busy}, 32'd1);
        rd_chk("ovr_status", BASE + 20'h10, 32'h4);
        wr(BASE + 20'h10, 32'h4, 4'h1);
        rd_chk("ovr_cleared", BASE + 20'h10, 32'h0);
        frame_start = 1'b1;
        wr(BASE + 20'h10, 32'h4, 4'h1);
        frame_start = 1'b0;
        rd_chk("ovr_set_wins", BASE + 20'h10, 32'h4);
        frame_done = 1'b1;
        tick();
        tick();
        rd_chk("ovr_done_status", BASE + 20'h10, 32'h5);
        rd_chk("ovr_fcnt", BASE + 20'h14, 32'd2);

        // ---- soft reset clears counters, keeps TIMEOUT_LIMIT
        wr(BASE + 20'h08, 32'h1, 4'h1);
        repeat (20) tick();
        chk("srst2_done", {31'd0, soft_rst}, 32'd0);
        rd_chk("srst2_fcnt", BASE + 20'h14, 32'd0);
        rd_chk("srst2_status", BASE + 20'h10, 32'd0);
        rd_chk("srst2_lat", BASE + 20'h18, 32'd0);
        rd_chk("srst2_tlim", BASE + 20'h1C, 32'd50);

        // ---- byte strobe on TIMEOUT_LIMIT from reset value
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        wr(BASE + 20'h1C, 32'hAABBCCDD, 4'h2);
        rd_chk("tlim_strobe", BASE + 20'h1C, 32'hFFFFCCFF);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
